// File: rtl/rfu_mc_pkg.sv
// rfu_mc_pkg: shared types and constants for the multi-CDB register file unit.
// Holds the default geometry, the reserved "no producer" tag, the CDB broadcast
// struct and the per-port read-result struct. The struct widths follow the
// PKG_* defaults, so any rfu_mc instance must use the same XLEN and TAG_W.
package rfu_mc_pkg;

    localparam int unsigned PKG_NREG  = 32;
    localparam int unsigned PKG_XLEN  = 32;
    localparam int unsigned PKG_TAG_W = 4;
    localparam int unsigned PKG_N_CDB = 2;

    localparam int unsigned REG_ADDR_W = $clog2(PKG_NREG);

    // Tag 0 means "no producer" and never matches a broadcast.
    localparam logic [PKG_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                 wr;
        logic [PKG_TAG_W-1:0] tag;
        logic [PKG_XLEN-1:0]  wdata;
    } cdb_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0]  rdata;
        logic                 busy;
        logic [PKG_TAG_W-1:0] tag;
    } rd_res_t;

endpackage

// File: rtl/rfu_mc_bypass.sv
// rfu_mc_bypass: combinational tag matcher over N_CDB broadcast buses.
// Reports whether any valid bus carries match_tag (only when match_en is set)
// and returns that bus's data; the lowest-numbered matching bus wins.
// Ports:
//   cdb        in   unpacked array of CDB broadcasts
//   match_en   in   the watched entry is waiting on a producer
//   match_tag  in   producer tag being watched
//   hit        out  a bus matched this cycle
//   data       out  data of the winning bus ('0 when no hit)
module rfu_mc_bypass
    import rfu_mc_pkg::*;
#(
    parameter int unsigned N_CDB = PKG_N_CDB
) (
    input  cdb_t                 cdb [N_CDB],
    input  logic                 match_en,
    input  logic [PKG_TAG_W-1:0] match_tag,
    output logic                 hit,
    output logic [PKG_XLEN-1:0]  data
);

    // Walk from the highest bus down so the lowest matching bus is the last writer.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = int'(N_CDB) - 1; k >= 0; k--) begin
            if (match_en && cdb[k].wr && (cdb[k].tag != TAG_NONE) &&
                (cdb[k].tag == match_tag)) begin
                hit  = 1'b1;
                data = cdb[k].wdata;
            end
        end
    end

endmodule

// File: rtl/rfu_mc.sv
// rfu_mc: architectural register file with per-register busy bit and producer
// tag, fed by N_CDB common data buses, with pipeline flush and a registered
// busy-register count for dispatch stalls.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_wr/rd_addr/rd_tag     rename of rd to a new producer tag
//   rs1_*/rs2_*              combinational source reads with CDB bypass
//   cdb_wr/cdb_tag/cdb_wdata packed broadcast buses (bus k at slice k)
//   flush                    squash all in-flight producers
//   busy_cnt                 registered count of busy registers 1..NREG-1
module rfu_mc
    import rfu_mc_pkg::*;
#(
    parameter int unsigned NREG  = PKG_NREG,
    parameter int unsigned XLEN  = PKG_XLEN,
    parameter int unsigned TAG_W = PKG_TAG_W,
    parameter int unsigned N_CDB = PKG_N_CDB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_wr,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    input  logic [TAG_W-1:0]         rd_tag,
    input  logic [$clog2(NREG)-1:0]  rs1_addr,
    input  logic [$clog2(NREG)-1:0]  rs2_addr,
    output logic [XLEN-1:0]          rs1_rdata,
    output logic [XLEN-1:0]          rs2_rdata,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [TAG_W-1:0]         rs1_tag,
    output logic [TAG_W-1:0]         rs2_tag,
    input  logic [N_CDB-1:0]         cdb_wr,
    input  logic [N_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [N_CDB*XLEN-1:0]    cdb_wdata,
    input  logic                     flush,
    output logic [$clog2(NREG):0]    busy_cnt
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = AW + 1;

    cdb_t cdb [N_CDB];

    logic [XLEN-1:0]  mem_q [NREG];
    logic [XLEN-1:0]  mem_d [NREG];
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [CW-1:0]    busy_cnt_q, busy_cnt_d;

    logic [NREG-1:0]  wb_hit;
    logic [XLEN-1:0]  wb_data [NREG];

    always_comb begin
        for (int k = 0; k < int'(N_CDB); k++) begin
            cdb[k].wr    = cdb_wr[k];
            cdb[k].tag   = cdb_tag[k*TAG_W +: TAG_W];
            cdb[k].wdata = cdb_wdata[k*XLEN +: XLEN];
        end
    end

    // Writeback match per register; register 0 never waits on anything.
    for (genvar i = 0; i < NREG; i++) begin : g_wb
        if (i == 0) begin : g_zero
            assign wb_hit[i]  = 1'b0;
            assign wb_data[i] = '0;
        end else begin : g_reg
            rfu_mc_bypass #(
                .N_CDB (N_CDB)
            ) u_wb_match (
                .cdb       (cdb),
                .match_en  (busy_q[i]),
                .match_tag (tag_q[i]),
                .hit       (wb_hit[i]),
                .data      (wb_data[i])
            );
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            mem_d[i]  = mem_q[i];
            busy_d[i] = busy_q[i];
            tag_d[i]  = tag_q[i];
        end
        for (int i = 1; i < int'(NREG); i++) begin
            if (flush) begin
                // Squash producers but keep data that lands in the same cycle.
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
                if (wb_hit[i]) mem_d[i] = wb_data[i];
            end else if (rd_wr && (rd_addr == AW'(i))) begin
                // Old producer's data is committed before the new one is installed.
                if (wb_hit[i]) mem_d[i] = wb_data[i];
                busy_d[i] = 1'b1;
                tag_d[i]  = rd_tag;
            end else if (wb_hit[i]) begin
                mem_d[i]  = wb_data[i];
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        if (!flush) begin
            for (int i = 1; i < int'(NREG); i++) begin
                busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= mem_d[i];
                tag_q[i] <= tag_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read ports: state before this cycle's update, with same-cycle CDB bypass.
    logic            rs1_hit, rs2_hit;
    logic [XLEN-1:0] rs1_byp, rs2_byp;
    rd_res_t         rs1_res, rs2_res;

    rfu_mc_bypass #(
        .N_CDB (N_CDB)
    ) u_rs1_byp (
        .cdb       (cdb),
        .match_en  (busy_q[rs1_addr]),
        .match_tag (tag_q[rs1_addr]),
        .hit       (rs1_hit),
        .data      (rs1_byp)
    );

    rfu_mc_bypass #(
        .N_CDB (N_CDB)
    ) u_rs2_byp (
        .cdb       (cdb),
        .match_en  (busy_q[rs2_addr]),
        .match_tag (tag_q[rs2_addr]),
        .hit       (rs2_hit),
        .data      (rs2_byp)
    );

    always_comb begin
        rs1_res = '{rdata: mem_q[rs1_addr], busy: busy_q[rs1_addr], tag: tag_q[rs1_addr]};
        if (rs1_addr == '0) begin
            rs1_res = '0;
        end else if (rs1_hit) begin
            rs1_res = '{rdata: rs1_byp, busy: 1'b0, tag: TAG_NONE};
        end
        rs2_res = '{rdata: mem_q[rs2_addr], busy: busy_q[rs2_addr], tag: tag_q[rs2_addr]};
        if (rs2_addr == '0) begin
            rs2_res = '0;
        end else if (rs2_hit) begin
            rs2_res = '{rdata: rs2_byp, busy: 1'b0, tag: TAG_NONE};
        end
    end

    assign rs1_rdata = rs1_res.rdata;
    assign rs1_busy  = rs1_res.busy;
    assign rs1_tag   = rs1_res.tag;
    assign rs2_rdata = rs2_res.rdata;
    assign rs2_busy  = rs2_res.busy;
    assign rs2_tag   = rs2_res.tag;

    // Two valid buses carrying the same live tag is a producer-side bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(N_CDB); k++) begin
                for (int j = k + 1; j < int'(N_CDB); j++) begin
                    assert (!(cdb[k].wr && cdb[j].wr && (cdb[k].tag != TAG_NONE) &&
                              (cdb[k].tag == cdb[j].tag)))
                    else $error("rfu_mc: duplicate live tag on CDB %0d and %0d", k, j);
                end
            end
        end
    end

endmodule

// File: tb/tb_rfu_mc.sv
module tb_rfu_mc;

    localparam int NREG  = 32;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int N_CDB = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rd_wr;
    logic [4:0]              rd_addr;
    logic [TAG_W-1:0]        rd_tag;
    logic [4:0]              rs1_addr, rs2_addr;
    logic [XLEN-1:0]         rs1_rdata, rs2_rdata;
    logic                    rs1_busy, rs2_busy;
    logic [TAG_W-1:0]        rs1_tag, rs2_tag;
    logic [N_CDB-1:0]        cdb_wr;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*XLEN-1:0]   cdb_wdata;
    logic                    flush;
    logic [5:0]              busy_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          kind;   // 0 = rs1, 1 = rs2, 2 = busy_cnt
        logic [31:0] data;
        logic        busy;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];

    rfu_mc #(
        .NREG  (NREG),
        .XLEN  (XLEN),
        .TAG_W (TAG_W),
        .N_CDB (N_CDB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_wr     (rd_wr),
        .rd_addr   (rd_addr),
        .rd_tag    (rd_tag),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_rdata (rs1_rdata),
        .rs2_rdata (rs2_rdata),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rs1_tag   (rs1_tag),
        .rs2_tag   (rs2_tag),
        .cdb_wr    (cdb_wr),
        .cdb_tag   (cdb_tag),
        .cdb_wdata (cdb_wdata),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic exp_rd(input string name, input int port, input logic [31:0] d,
                          input logic b, input logic [3:0] t);
        exp_t e;
        e.name = name; e.kind = port; e.data = d; e.busy = b; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input string name, input int c);
        exp_t e;
        e.name = name; e.kind = 2; e.data = 32'(c); e.busy = 1'b0; e.tag = '0;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then retire every pending expectation.
    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0: begin
                    cmp({e.name, ".rs1_rdata"}, rs1_rdata, e.data);
                    cmp({e.name, ".rs1_busy"}, 32'(rs1_busy), 32'(e.busy));
                    cmp({e.name, ".rs1_tag"}, 32'(rs1_tag), 32'(e.tag));
                end
                1: begin
                    cmp({e.name, ".rs2_rdata"}, rs2_rdata, e.data);
                    cmp({e.name, ".rs2_busy"}, 32'(rs2_busy), 32'(e.busy));
                    cmp({e.name, ".rs2_tag"}, 32'(rs2_tag), 32'(e.tag));
                end
                default: cmp({e.name, ".busy_cnt"}, 32'(busy_cnt), e.data);
            endcase
        end
    endtask

    task automatic idle();
        rd_wr = 1'b0; rd_addr = '0; rd_tag = '0;
        cdb_wr = '0; cdb_tag = '0; cdb_wdata = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input int r, input int t);
        rd_wr = 1'b1; rd_addr = 5'(r); rd_tag = 4'(t);
    endtask

    task automatic bcast(input int k, input int t, input logic [31:0] d);
        cdb_wr[k] = 1'b1;
        cdb_tag[k*TAG_W +: TAG_W] = 4'(t);
        cdb_wdata[k*XLEN +: XLEN] = d;
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = '0; rs2_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        rs1_addr = 5; rs2_addr = 0;
        exp_rd("reset", 0, 32'h0, 1'b0, 4'd0);
        exp_rd("reset", 1, 32'h0, 1'b0, 4'd0);
        exp_cnt("reset", 0);
        drain();

        // Async reset mid-cycle clears a live rename before the next edge
        rename(5, 3);
        tick();
        exp_rd("pre_arst", 0, 32'h0, 1'b1, 4'd3);
        exp_cnt("pre_arst", 1);
        drain();
        #1 rst = 1'b1;
        exp_rd("arst", 0, 32'h0, 1'b0, 4'd0);
        exp_cnt("arst", 0);
        drain();
        #1 rst = 1'b0;
        tick();

        // Rename x5, then CDB1 bypass and writeback
        rs1_addr = 5;
        rename(5, 3);
        exp_rd("ren5_same", 0, 32'h0, 1'b0, 4'd0);
        drain();
        tick();
        exp_rd("ren5_next", 0, 32'h0, 1'b1, 4'd3);
        exp_cnt("ren5_next", 1);
        drain();
        bcast(1, 3, 32'hDEADBEEF);
        exp_rd("byp5", 0, 32'hDEADBEEF, 1'b0, 4'd0);
        drain();
        tick();
        exp_rd("wb5", 0, 32'hDEADBEEF, 1'b0, 4'd0);
        exp_cnt("wb5", 0);
        drain();

        // Rename collision on x7
        rs1_addr = 7;
        rename(7, 2);
        tick();
        exp_rd("ren7", 0, 32'h0, 1'b1, 4'd2);
        exp_cnt("ren7", 1);
        drain();
        rename(7, 9);
        bcast(0, 2, 32'h11);
        exp_rd("coll7_same", 0, 32'h11, 1'b0, 4'd0);
        drain();
        tick();
        exp_rd("coll7_next", 0, 32'h11, 1'b1, 4'd9);
        exp_cnt("coll7_next", 1);
        drain();
        bcast(0, 2, 32'h99);
        exp_rd("stale7_same", 0, 32'h11, 1'b1, 4'd9);
        drain();
        tick();
        exp_rd("stale7_next", 0, 32'h11, 1'b1, 4'd9);
        exp_cnt("stale7_next", 1);
        drain();
        bcast(0, 9, 32'h22);
        tick();
        exp_rd("wb7", 0, 32'h22, 1'b0, 4'd0);
        exp_cnt("wb7", 0);
        drain();

        // Two buses retire two registers in one cycle
        rs1_addr = 1; rs2_addr = 2;
        rename(1, 4);
        tick();
        rename(2, 5);
        tick();
        exp_rd("dual_pend", 0, 32'h0, 1'b1, 4'd4);
        exp_rd("dual_pend", 1, 32'h0, 1'b1, 4'd5);
        exp_cnt("dual_pend", 2);
        drain();
        bcast(0, 4, 32'hA);
        bcast(1, 5, 32'hB);
        tick();
        exp_rd("dual_wb", 0, 32'hA, 1'b0, 4'd0);
        exp_rd("dual_wb", 1, 32'hB, 1'b0, 4'd0);
        exp_cnt("dual_wb", 0);
        drain();

        // Flush with a same-cycle writeback
        rename(3, 1);
        tick();
        rename(4, 2);
        tick();
        rename(6, 3);
        tick();
        rs1_addr = 3; rs2_addr = 4;
        exp_cnt("pre_flush", 3);
        drain();
        flush = 1'b1;
        bcast(0, 1, 32'h55);
        exp_rd("flush_same", 0, 32'h55, 1'b0, 4'd0);
        exp_rd("flush_same", 1, 32'h0, 1'b1, 4'd2);
        drain();
        tick();
        exp_rd("flush_next", 0, 32'h55, 1'b0, 4'd0);
        exp_rd("flush_next", 1, 32'h0, 1'b0, 4'd0);
        exp_cnt("flush_next", 0);
        drain();
        rs1_addr = 6;
        bcast(0, 2, 32'h77);
        exp_rd("post_flush6", 0, 32'h0, 1'b0, 4'd0);
        exp_rd("post_flush4", 1, 32'h0, 1'b0, 4'd0);
        drain();
        tick();
        exp_rd("post_flush4_next", 1, 32'h0, 1'b0, 4'd0);
        exp_cnt("post_flush_next", 0);
        drain();

        // Register 0 ignores renames and writebacks
        rename(9, 7);
        tick();
        rs1_addr = 0;
        rename(0, 6);
        bcast(1, 6, 32'h66);
        exp_rd("x0_same", 0, 32'h0, 1'b0, 4'd0);
        exp_cnt("x0_same", 1);
        drain();
        tick();
        exp_rd("x0_next", 0, 32'h0, 1'b0, 4'd0);
        exp_cnt("x0_next", 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rfu_mc.md
Name: rfu_mc

Overview:
- Parametrised successor to the single-CDB register file unit.
- Architectural register file with per-register busy bit and producer tag (Tomasulo-style renaming), sitting between decode/dispatch and the common data buses.
- Generalised to NREG registers, XLEN data, N_CDB broadcast buses and a pipeline flush.
- Fixes rename/writeback collisions: data is not lost when a register is renamed in the cycle its old producer broadcasts. Exposes a busy-register count for the dispatch stall logic.

Parameters:
- NREG, 32, architectural register count (power of two, >= 2); register 0 is hard-wired zero.
- XLEN, 32, data width.
- TAG_W, 4, producer tag width; tag value 0 is reserved as "no producer".
- N_CDB, 2, number of CDB broadcast ports.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rd_wr  in  1  dispatch renames rd this cycle.
- rd_addr  in  $clog2(NREG)  destination register.
- rd_tag  in  TAG_W  new producer tag; non-zero when rd_wr=1.
- rs1_addr, rs2_addr  in  $clog2(NREG)  source read addresses.
- rs1_rdata, rs2_rdata  out  XLEN  source value (bypassed).
- rs1_busy, rs2_busy  out  1  source still pending.
- rs1_tag, rs2_tag  out  TAG_W  pending producer tag; 0 when not busy.
- cdb_wr  in  N_CDB  per-bus broadcast valid.
- cdb_tag  in  N_CDB*TAG_W  packed broadcast tags.
- cdb_wdata  in  N_CDB*XLEN  packed broadcast data.
- flush  in  1  squash all in-flight producers.
- busy_cnt  out  $clog2(NREG)+1  registered count of busy registers.

Behaviour:
- Reset (asynchronous, rst=1): all mem = 0, busy = 0, tag = 0, busy_cnt = 0. Read outputs then reflect zero contents.
- Register 0: always mem=0, busy=0, tag=0. Renames and writebacks to it are ignored.
- Writeback match for register i (i != 0): busy[i]=1, cdb_wr[k]=1 and cdb_tag[k]==tag[i].
  - CDB tag 0 never matches.
  - If several buses match, lowest k wins. Duplicate live tags on CDBs are illegal and flagged by an assertion.
- Per-register update priority, evaluated each posedge:
  - flush: busy=0, tag=0, mem unchanged. A same-cycle CDB match still writes mem.
  - Else if rename hits i and a CDB matches the old tag: mem <= CDB data, busy=1, tag=rd_tag. Data is committed and the new producer is installed.
  - Else if rename hits i: busy=1, tag=rd_tag.
  - Else if a CDB matches: mem <= data, busy=0, tag=0.
- Reads are combinational and see state before this cycle's rename. An instruction whose rd equals its rs1 gets the old mapping.
- Read bypass: if a CDB matches the source's current busy tag this cycle, the port returns that CDB's data with busy=0, tag=0 (lowest k wins). Otherwise it returns stored mem/busy/tag. Address 0 always returns 0/0/0.
- Flush does not affect combinational read outputs in the flush cycle. Dispatch is blocked by the core during flush.
- busy_cnt:
  - Registered population count of busy[NREG-1:1] after the update.
  - Next value is 0 on flush.
  - Range 0..NREG-1. Never wraps.
- Latency: rename and writeback are visible on the read ports the cycle after they are presented; CDB data is also visible the same cycle via bypass.
- rst asserted mid-operation clears state immediately, independent of clk.

Decomposition:
- Shared package holds: REG_ADDR_W, TAG_NONE = '0, cdb_t struct {wr, tag, wdata} and the per-port read-result struct.
- One sub-module is natural: rfu_mc_bypass, a combinational N_CDB tag matcher and priority selector.
  - Instantiated once per read port.
  - Also reused per register for writeback match.

Test Plan:
- Reset then read rs1=5, rs2=0 -> rdata 0, busy 0, tag 0, busy_cnt 0; re-assert rst asynchronously mid-cycle -> outputs clear before next edge.
- Rename x5 tag 3; next cycle read x5 -> busy 1, tag 3, busy_cnt 1; CDB1 broadcasts tag 3 data 0xDEADBEEF -> same-cycle rs1 rdata 0xDEADBEEF busy 0; next cycle stored, busy_cnt 0.
- Rename x7 tag 2; later same cycle: rename x7 tag 9 and CDB0 tag 2 data 0x11 -> next cycle mem[x7]=0x11, busy 1, tag 9; CDB tag 2 again -> no change; CDB tag 9 data 0x22 -> mem 0x22, busy 0.
- Rename x1 tag 4, x2 tag 5; both CDBs fire (tag 4 data 0xA, tag 5 data 0xB) in one cycle -> x1=0xA, x2=0xB, busy_cnt 2 -> 0.
- Rename x3, x4, x6 (tags 1, 2, 3), then flush with CDB0 tag 1 data 0x55 -> all busy 0, x3=0x55, x4/x6 unchanged, busy_cnt 0; later CDB tag 2 -> ignored.
- Rename x0 tag 6 and CDB tag 6 -> x0 reads 0, busy 0, busy_cnt unchanged.
